// File: rtl/ace_snoop_responder.sv
// ACE snoop-channel responder: buffers AC snoops, answers on CR in arrival order after a
// per-snoop delay, and streams a deterministic address pattern on CD when DataTransfer is set.
module ace_snoop_responder #(
    parameter int ADDR_WIDTH       = 44,
    parameter int SNOOP_DATA_WIDTH = 128,
    parameter int CACHE_LINE_SIZE  = 6,
    parameter int SNOOP_DEPTH      = 4,
    parameter int DELAY_WIDTH      = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        ACVALID,
    output logic                        ACREADY,
    input  logic [ADDR_WIDTH-1:0]       ACADDR,
    input  logic [3:0]                  ACSNOOP,
    input  logic [2:0]                  ACPROT,
    output logic                        CRVALID,
    input  logic                        CRREADY,
    output logic [4:0]                  CRRESP,
    output logic                        CDVALID,
    input  logic                        CDREADY,
    output logic [SNOOP_DATA_WIDTH-1:0] CDDATA,
    output logic                        CDLAST,
    input  logic [4:0]                  cfg_crresp,
    input  logic [DELAY_WIDTH-1:0]      cfg_delay,
    output logic                        busy,
    output logic [15:0]                 snoop_cnt
);

    localparam int BYTES  = SNOOP_DATA_WIDTH / 8;
    localparam int BEATS  = (2 ** CACHE_LINE_SIZE) / BYTES;
    localparam int LANES  = SNOOP_DATA_WIDTH / 32;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = (SNOOP_DEPTH > 1) ? $clog2(SNOOP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(SNOOP_DEPTH + 1);

    localparam logic [31:0]       LINE_MASK = ~((32'd1 << CACHE_LINE_SIZE) - 32'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(SNOOP_DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(SNOOP_DEPTH);

    typedef enum logic [1:0] {IDLE, DELAY, RESP, DATA} state_t;

    state_t                  state;
    logic [DELAY_WIDTH-1:0]  dly_cnt;
    logic [BEAT_W-1:0]       beat;

    logic [31:0]             base_mem  [SNOOP_DEPTH];
    logic [3:0]              snoop_mem [SNOOP_DEPTH];
    logic [2:0]              prot_mem  [SNOOP_DEPTH];
    logic [4:0]              resp_mem  [SNOOP_DEPTH];
    logic [DELAY_WIDTH-1:0]  delay_mem [SNOOP_DEPTH];

    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    push;
    logic                    pop;
    logic [ADDR_WIDTH+31:0]  addr_ext;
    logic [31:0]             ac_base;
    logic [4:0]              ac_resp;
    logic [31:0]             head_base;
    logic [4:0]              head_resp;
    logic [DELAY_WIDTH-1:0]  head_delay;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Lane j of beat k carries line_base + k*BYTES + 4*j, wrapping at 32 bits.
    function automatic logic [SNOOP_DATA_WIDTH-1:0] beat_data(input logic [31:0] base,
                                                              input logic [BEAT_W-1:0] k);
        logic [SNOOP_DATA_WIDTH-1:0] d;
        d = '0;
        for (int j = 0; j < LANES; j++) begin
            d[32*j +: 32] = base + (32'(k) * 32'(BYTES)) + 32'(4 * j);
        end
        return d;
    endfunction

    assign ACREADY    = !ARESET && (count < DEPTH_C);
    assign push       = ACVALID && ACREADY;
    assign addr_ext   = {32'd0, ACADDR};
    assign ac_base    = addr_ext[31:0] & LINE_MASK;
    assign ac_resp    = (ACSNOOP == 4'b1101) ? {cfg_crresp[4:1], 1'b0} : cfg_crresp;
    assign head_base  = base_mem[rd_ptr];
    assign head_resp  = resp_mem[rd_ptr];
    assign head_delay = delay_mem[rd_ptr];
    assign pop        = ((state == RESP) && CRREADY && !CRRESP[0]) ||
                        ((state == DATA) && CDREADY && CDLAST);
    assign busy       = (state != IDLE) || (count != '0);

    always_ff @(posedge ACLK) begin
        if (push) begin
            base_mem[wr_ptr]  <= ac_base;
            snoop_mem[wr_ptr] <= ACSNOOP;
            prot_mem[wr_ptr]  <= ACPROT;
            resp_mem[wr_ptr]  <= ac_resp;
            delay_mem[wr_ptr] <= cfg_delay;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Only the head entry is ever serviced, so responses leave strictly in AC order.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            dly_cnt   <= '0;
            beat      <= '0;
            CRVALID   <= 1'b0;
            CRRESP    <= '0;
            CDVALID   <= 1'b0;
            CDDATA    <= '0;
            CDLAST    <= 1'b0;
            snoop_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        if (head_delay != '0) begin
                            state   <= DELAY;
                            dly_cnt <= head_delay;
                        end else begin
                            state   <= RESP;
                            CRVALID <= 1'b1;
                            CRRESP  <= head_resp;
                        end
                    end
                end
                DELAY: begin
                    if (dly_cnt == DELAY_WIDTH'(1)) begin
                        state   <= RESP;
                        CRVALID <= 1'b1;
                        CRRESP  <= head_resp;
                    end else begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (CRREADY) begin
                        CRVALID <= 1'b0;
                        if (CRRESP[0]) begin
                            state   <= DATA;
                            beat    <= '0;
                            CDVALID <= 1'b1;
                            CDDATA  <= beat_data(head_base, '0);
                            CDLAST  <= (LAST_BEAT == '0);
                        end else begin
                            state     <= IDLE;
                            snoop_cnt <= snoop_cnt + 16'd1;
                        end
                    end
                end
                DATA: begin
                    if (CDREADY) begin
                        if (CDLAST) begin
                            state     <= IDLE;
                            CDVALID   <= 1'b0;
                            CDLAST    <= 1'b0;
                            snoop_cnt <= snoop_cnt + 16'd1;
                        end else begin
                            beat   <= beat + 1'b1;
                            CDDATA <= beat_data(head_base, beat + 1'b1);
                            CDLAST <= ((beat + 1'b1) == LAST_BEAT);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
